// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and its environment: control/results plus the
// vector/response pair that connects to the function under test.
interface truth_table_sweeper_if;
  logic        start;
  logic [15:0] exp_tbl;
  logic        f;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic        first_err_valid;
  logic [3:0]  first_err_idx;
  logic [15:0] obs_tbl;

  modport slave (
    input  start, exp_tbl, f,
    output a, b, c, d, busy, done, pass, err_count,
           first_err_valid, first_err_idx, obs_tbl
  );

  modport master (
    output start, exp_tbl, f,
    input  a, b, c, d, busy, done, pass, err_count,
           first_err_valid, first_err_idx, obs_tbl
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper: walks {a,b,c,d} through 0..15,
// samples f after a settle time and scores it against an expected table.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TBL_W = 16;
  localparam int unsigned ERR_W = 5;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TBL_W-1:0]   exp_q, exp_d;
  logic [TBL_W-1:0]   obs_q, obs_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   fei_q, fei_d;
  logic               fev_q, fev_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      obs_q   <= '0;
      err_q   <= '0;
      fei_q   <= '0;
      fev_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      err_q   <= err_d;
      fei_q   <= fei_d;
      fev_q   <= fev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    obs_d   = obs_q;
    err_d   = err_q;
    fei_d   = fei_q;
    fev_d   = fev_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          exp_d   = bus.exp_tbl;
          obs_d   = '0;
          err_d   = '0;
          fei_d   = '0;
          fev_d   = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        obs_d[idx_q] = bus.f;
        if (bus.f != exp_q[idx_q]) begin
          err_d = err_q + ERR_W'(1);
          if (!fev_q) begin
            fei_d = idx_q;
            fev_d = 1'b1;
          end
        end
        // Last vector: vector stays at 1111, results become final here.
        if (idx_q == IDX_W'(TBL_W - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = APPLY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.a               = idx_q[3];
  assign bus.b               = idx_q[2];
  assign bus.c               = idx_q[1];
  assign bus.d               = idx_q[0];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx   = fei_q;
  assign bus.obs_tbl         = obs_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 2 and settle 1) driven
// by a table-lookup function model, scored against a truth-table reference.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_r [2];
  logic [15:0] exp_r   [2];
  logic [15:0] ftbl    [2];

  truth_table_sweeper_if if0();
  truth_table_sweeper_if if1();

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.start   = start_r[0];
  assign if0.exp_tbl = exp_r[0];
  assign if0.f       = ftbl[0][{if0.a, if0.b, if0.c, if0.d}];
  assign if1.start   = start_r[1];
  assign if1.exp_tbl = exp_r[1];
  assign if1.f       = ftbl[1][{if1.a, if1.b, if1.c, if1.d}];

  logic [3:0]  vec    [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic        pass_o [2];
  logic [4:0]  errc_o [2];
  logic        fev_o  [2];
  logic [3:0]  fei_o  [2];
  logic [15:0] obs_o  [2];

  assign vec[0]    = {if0.a, if0.b, if0.c, if0.d};
  assign busy_o[0] = if0.busy;
  assign done_o[0] = if0.done;
  assign pass_o[0] = if0.pass;
  assign errc_o[0] = if0.err_count;
  assign fev_o[0]  = if0.first_err_valid;
  assign fei_o[0]  = if0.first_err_idx;
  assign obs_o[0]  = if0.obs_tbl;
  assign vec[1]    = {if1.a, if1.b, if1.c, if1.d};
  assign busy_o[1] = if1.busy;
  assign done_o[1] = if1.done;
  assign pass_o[1] = if1.pass;
  assign errc_o[1] = if1.err_count;
  assign fev_o[1]  = if1.first_err_valid;
  assign fei_o[1]  = if1.first_err_idx;
  assign obs_o[1]  = if1.obs_tbl;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] outs(input int s);
    return 64'({vec[s], busy_o[s], done_o[s], pass_o[s], errc_o[s],
                fev_o[s], fei_o[s], obs_o[s]});
  endfunction

  // Reference scoring: mismatches are just the differing bits of the two tables.
  task automatic check_results(input int s, input logic [15:0] expv,
                               input logic [15:0] ft, input string tag);
    int errs  = 0;
    int first = -1;
    for (int i = 0; i < 16; i++) begin
      if (expv[i] != ft[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    check({tag, " err_count"},       64'(errc_o[s]), 64'(errs));
    check({tag, " pass"},            64'(pass_o[s]), 64'(errs == 0));
    check({tag, " first_err_valid"}, 64'(fev_o[s]),  64'(first >= 0));
    check({tag, " first_err_idx"},   64'(fei_o[s]),  64'((first >= 0) ? first : 0));
    check({tag, " obs_tbl"},         64'(obs_o[s]),  64'(ft));
  endtask

  // One sweep; k counts edges after the accepting edge, sampled at negedge.
  task automatic sweep(input int s, input logic [15:0] expv, input logic [15:0] ft,
                       input int restart_at, input int abort_at, input string tag);
    int sc = (s == 0) ? 2 : 1;
    int n  = 16 * (sc + 1);
    ftbl[s]  = ft;
    exp_r[s] = expv;
    @(negedge clk);
    start_r[s] = 1'b1;
    @(negedge clk);
    start_r[s] = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check({tag, " outputs after reset"}, outs(s), 64'd0);
        rst = 1'b0;
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          check({tag, " idle after reset"}, 64'({busy_o[s], done_o[s]}), 64'd0);
        end
        return;
      end
      if (k == restart_at) begin
        start_r[s] = 1'b1;
        exp_r[s]   = 16'h0000;
      end else if (k == restart_at + 1) begin
        start_r[s] = 1'b0;
      end
      if (k < n) begin
        check($sformatf("%s busy k=%0d", tag, k), 64'(busy_o[s]), 64'd1);
        check($sformatf("%s done k=%0d", tag, k), 64'(done_o[s]), 64'd0);
        check($sformatf("%s vector k=%0d", tag, k), 64'(vec[s]), 64'(k / (sc + 1)));
      end else if (k == n) begin
        check({tag, " done pulse"}, 64'(done_o[s]), 64'd1);
        check({tag, " busy at done"}, 64'(busy_o[s]), 64'd0);
        check({tag, " vector at done"}, 64'(vec[s]), 64'd15);
        check_results(s, expv, ft, {tag, " at done"});
      end else begin
        check({tag, " done after pulse"}, 64'({busy_o[s], done_o[s]}), 64'd0);
        check({tag, " vector held"}, 64'(vec[s]), 64'd15);
        check_results(s, expv, ft, {tag, " held"});
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start_r[0] = 1'b1;
    start_r[1] = 1'b1;
    exp_r[0]   = 16'hFFFF;
    exp_r[1]   = 16'hFFFF;
    ftbl[0]    = 16'h0000;
    ftbl[1]    = 16'h0000;

    // Reset held with start high, then quiet idle
    repeat (2) @(negedge clk);
    check("reset outputs dut0", outs(0), 64'd0);
    check("reset outputs dut1", outs(1), 64'd0);
    rst        = 1'b0;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("idle dut0", outs(0), 64'd0);
      check("idle dut1", outs(1), 64'd0);
    end

    sweep(0, 16'hB0BB, 16'hB0BB, -1, -1, "golden");
    sweep(0, 16'hB0BB, 16'h0000, -1, -1, "stuck0");
    sweep(0, 16'hB0BB, 16'hB2BB, -1, -1, "fault9");
    sweep(0, 16'hB0BB, 16'hB0BB, 20, -1, "restart");
    sweep(1, 16'hB0BB, 16'hB0BB, -1, 15, "abort");
    sweep(1, 16'hB0BB, 16'hB0BB, -1, -1, "short");

    for (int r = 0; r < 8; r++) begin
      int          s  = r % 2;
      int          n  = 16 * (((s == 0) ? 2 : 1) + 1);
      logic [15:0] e  = 16'($urandom);
      logic [15:0] m  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if (r == 2) m = 16'h0000;
      if (r == 3) m = 16'hFFFF;
      sweep(s, e, e ^ m, (r == 4) ? n : -1, -1, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
